// File: rtl/mux_sel_scheduler_pkg.sv
// Shared definitions for the round-robin mux select scheduler:
// channel encodings, FSM state type and the reset value of the
// round-robin pointer.
package mux_sel_scheduler_pkg;

  // Channel encodings, matching the {S1,S0} select of the downstream 4x1 mux.
  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  // The pointer resets to the last channel so that the first search starts at channel A.
  localparam logic [1:0] RST_LAST = CH_D;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_VALID = 2'd2
  } state_t;

endpackage

// File: rtl/mux_sel_scheduler_pick.sv
// Combinational round-robin picker. It searches req in the order
// last+1, last+2, last+3, last (modulo 4) and returns the first
// requesting channel. any flags that at least one request is present.
module rr_pick4
  import mux_sel_scheduler_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] win,
  output logic       any
);

  // Walk the search order from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; otherwise a path that skips the assignment infers a latch.
    win = last;
    any = |req;
    for (int k = 4; k >= 1; k--) begin
      if (req[2'(last + 2'(k))]) begin
        win = 2'(last + 2'(k));
      end
    end
  end

endmodule

// File: rtl/mux_sel_scheduler.sv
// Round-robin select sequencer for a 4x1 mux. It grants one of four
// channel requests, parks the mux select on the winner for Dwell
// cycles, then raises Valid until the consumer acknowledges.
// All outputs are registered.
module mux_sel_scheduler
  import mux_sel_scheduler_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               En,
  input  logic [3:0]         Req,
  input  logic [DWELL_W-1:0] Dwell,
  input  logic               Ack,
  output logic               S1,
  output logic               S0,
  output logic               Valid,
  output logic               Busy
);

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [1:0]         last;
  logic [1:0]         win;
  logic               any;

  rr_pick4 u_pick (
    .req  (Req),
    .last (last),
    .win  (win),
    .any  (any)
  );

  // Scheduler FSM with dwell counter, round-robin pointer and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
      state <= ST_IDLE;
      cnt   <= '0;
      last  <= RST_LAST;
      S1    <= 1'b0;
      S0    <= 1'b0;
      Valid <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (En && any) begin
            {S1, S0} <= win;
            last     <= win;
            cnt      <= Dwell;
            Busy     <= 1'b1;
            if (Dwell != '0) begin
              state <= ST_HOLD;
            end else begin
              state <= ST_VALID;
              Valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // The grant is committed here: Req, En and Dwell are not looked at.
          if (cnt == DWELL_W'(1)) begin
            state <= ST_VALID;
            Valid <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt - DWELL_W'(1);
          end
        end
        ST_VALID: begin
          if (Ack) begin
            state <= ST_IDLE;
            Valid <= 1'b0;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          Valid <= 1'b0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
